hazard_forward_unit: RTL and testbench

//  Control-side counterpart of the rs1mux/rs2mux/dcachemux select encodings: generates the forwarding selects those datapath muxes consume.

---
 rtl/hazard_forward_unit.sv | 126 ++++++++++++
 tb/tb_hazard_forward_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// Forwarding-select and load-use stall control for a 5-stage RV32I pipeline.
// Keeps a shadow EX/MEM/WB scoreboard that advances with the pipeline registers.
module hazard_forward_unit #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_load,
  input  logic             id_store,
  input  logic             mem_stall,
  input  logic             flush,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic [SEL_W-1:0] rs1mux_sel,
  output logic [SEL_W-1:0] rs2mux_sel,
  output logic             dcachemux_sel
);

  localparam logic [SEL_W-1:0] SEL_RF    = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_EXMEM = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_MEMWB = SEL_W'(2);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             load;
    logic             store;
    logic [REG_W-1:0] rs2;
  } shadow_t;

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } state_t;

  state_t  state_q, state_d;
  shadow_t ex_q, mem_q, wb_q;
  shadow_t id_entry;
  logic    hazard_c;
  logic    stall_c;
  logic    kill_c;
  logic    dcm_d;

  // Select for one EX operand given the producers about to sit in EX/MEM and MEM/WB.
  function automatic logic [SEL_W-1:0] fwd_sel(input logic use_rs, input logic [REG_W-1:0] rs,
                                               input shadow_t ex, input shadow_t mem);
    if (!use_rs || rs == '0)
      return SEL_RF;
    if (ex.valid && ex.regwrite && !ex.load && ex.rd == rs)
      return SEL_EXMEM;
    if (mem.valid && mem.regwrite && mem.rd == rs)
      return SEL_MEMWB;
    return SEL_RF;
  endfunction

  always_comb begin
    id_entry = '{valid: id_valid, rd: id_rd, regwrite: id_regwrite,
                 load: id_load, store: id_store, rs2: id_rs2};
    // Store data is exempt: it is patched later through dcachemux.
    hazard_c = ex_q.valid && ex_q.load && (ex_q.rd != '0) && id_valid &&
               ((id_use_rs1 && id_rs1 == ex_q.rd) ||
                (id_use_rs2 && !id_store && id_rs2 == ex_q.rd));
    dcm_d    = ex_q.valid && ex_q.store && (ex_q.rs2 != '0) &&
               mem_q.valid && mem_q.regwrite && (mem_q.rd == ex_q.rs2);
  end

  always_comb begin
    state_d = state_q;
    stall_c = 1'b0;
    case (state_q)
      RUN: begin
        if (hazard_c && !flush) begin
          stall_c = 1'b1;
          if (!mem_stall)
            state_d = LU_STALL;
        end
      end
      LU_STALL: begin
        if (!mem_stall)
          state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (flush && !mem_stall)
      state_d = RUN;
  end

  assign stall_id  = stall_c;
  assign bubble_ex = stall_c;
  assign kill_c    = stall_c || flush || !id_valid;

  // Everything freezes while the caches hold the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      rs1mux_sel    <= SEL_RF;
      rs2mux_sel    <= SEL_RF;
      dcachemux_sel <= 1'b0;
    end else if (!mem_stall) begin
      state_q       <= state_d;
      ex_q          <= kill_c ? shadow_t'('0) : id_entry;
      mem_q         <= ex_q;
      wb_q          <= mem_q;
      rs1mux_sel    <= kill_c ? SEL_RF : fwd_sel(id_use_rs1, id_rs1, ex_q, mem_q);
      rs2mux_sel    <= kill_c ? SEL_RF : fwd_sel(id_use_rs2, id_rs2, ex_q, mem_q);
      dcachemux_sel <= dcm_d;
    end
  end

  // WB and some MEM fields track the pipeline but feed no select.
  logic unused_shadow;
  assign unused_shadow = ^{wb_q, mem_q.load, mem_q.store, mem_q.rs2};

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed test of hazard_forward_unit: forwarding selects, load-use stall, flush, mem_stall, reset.
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_regwrite, id_load, id_store;
  logic       mem_stall, flush;
  logic       stall_id, bubble_ex, dcachemux_sel;
  logic [1:0] rs1mux_sel, rs2mux_sel;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(.REG_W(5), .SEL_W(2)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_load(id_load), .id_store(id_store),
    .mem_stall(mem_stall), .flush(flush), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .rs1mux_sel(rs1mux_sel), .rs2mux_sel(rs2mux_sel), .dcachemux_sel(dcachemux_sel)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic ld, input logic st);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_regwrite = rw; id_load = ld; id_store = st;
  endtask

  task automatic idle();                       set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic alu(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
                                               set_id(1, a, 1, b, 1, rd, 1, 0, 0); endtask
  task automatic alui(input logic [4:0] rd, input logic [4:0] a);
                                               set_id(1, a, 1, 0, 0, rd, 1, 0, 0); endtask
  task automatic lw(input logic [4:0] rd, input logic [4:0] a);
                                               set_id(1, a, 1, 0, 0, rd, 1, 1, 0); endtask
  task automatic sw(input logic [4:0] a, input logic [4:0] d);
                                               set_id(1, a, 1, d, 0, 0, 0, 0, 1); endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".stall"}, 8'(stall_id), 8'h0);
    chk({tag, ".bubble"}, 8'(bubble_ex), 8'h0);
    chk({tag, ".rs1"}, 8'(rs1mux_sel), 8'h0);
    chk({tag, ".rs2"}, 8'(rs2mux_sel), 8'h0);
    chk({tag, ".dcm"}, 8'(dcachemux_sel), 8'h0);
  endtask

  initial begin
    rst = 1'b1; mem_stall = 1'b0; flush = 1'b0;
    idle();
    #1;
    repeat (2) tick();
    chk_all_zero("reset");
    rst = 1'b0;

    // add x5,x1,x2 ; sub x6,x5,x3
    alu(5, 1, 2); tick();
    alu(6, 5, 3); #1;
    chk("exmem.stall", 8'(stall_id), 8'h0);
    tick();
    chk("exmem.rs1", 8'(rs1mux_sel), 8'h1);
    chk("exmem.rs2", 8'(rs2mux_sel), 8'h0);

    // add x5 ; nop ; or x7,x2,x5
    drain();
    alu(5, 1, 2); tick();
    idle(); tick();
    alu(7, 2, 5); tick();
    chk("memwb.rs1", 8'(rs1mux_sel), 8'h0);
    chk("memwb.rs2", 8'(rs2mux_sel), 8'h2);

    // add x5 ; addi x5 ; or x7,x2,x5 : nearer producer wins
    drain();
    alu(5, 1, 2); tick();
    alui(5, 1); tick();
    alu(7, 2, 5); tick();
    chk("prio.rs2", 8'(rs2mux_sel), 8'h1);

    // lw x8,0(x1) ; add x9,x8,x8
    drain();
    lw(8, 1); tick();
    alu(9, 8, 8); #1;
    chk("lu.stall", 8'(stall_id), 8'h1);
    chk("lu.bubble", 8'(bubble_ex), 8'h1);
    tick();
    chk("lu.stall_end", 8'(stall_id), 8'h0);
    chk("lu.bubble_end", 8'(bubble_ex), 8'h0);
    chk("lu.bub_rs1", 8'(rs1mux_sel), 8'h0);
    tick();
    chk("lu.rs1", 8'(rs1mux_sel), 8'h2);
    chk("lu.rs2", 8'(rs2mux_sel), 8'h2);
    chk("lu.no_restall", 8'(stall_id), 8'h0);

    // lw x8 ; sw x8,4(x2) : no stall, store data patched in MEM
    drain();
    lw(8, 1); tick();
    sw(2, 8); #1;
    chk("st.stall", 8'(stall_id), 8'h0);
    tick();
    chk("st.rs1", 8'(rs1mux_sel), 8'h0);
    chk("st.dcm_ex", 8'(dcachemux_sel), 8'h0);
    idle(); tick();
    chk("st.dcm", 8'(dcachemux_sel), 8'h1);
    tick();
    chk("st.dcm_clr", 8'(dcachemux_sel), 8'h0);

    // add x0,x1,x2 ; add x3,x0,x0
    drain();
    alu(0, 1, 2); tick();
    alu(3, 0, 0); tick();
    chk("x0.rs1", 8'(rs1mux_sel), 8'h0);
    chk("x0.rs2", 8'(rs2mux_sel), 8'h0);

    // Load-use hazard with flush in the same cycle
    drain();
    lw(8, 1); tick();
    alu(9, 8, 8); flush = 1'b1; #1;
    chk("fl.stall", 8'(stall_id), 8'h0);
    chk("fl.bubble", 8'(bubble_ex), 8'h0);
    tick();
    flush = 1'b0;
    chk("fl.rs1", 8'(rs1mux_sel), 8'h0);
    chk("fl.rs2", 8'(rs2mux_sel), 8'h0);
    alu(10, 9, 0); tick();
    chk("fl.ex_invalid", 8'(rs1mux_sel), 8'h0);

    // Load-use hazard held by mem_stall for 3 cycles
    drain();
    alu(1, 2, 3); tick();
    lw(8, 1); tick();
    chk("ms.pre_rs1", 8'(rs1mux_sel), 8'h1);
    alu(9, 8, 8); mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ms.frz_stall", 8'(stall_id), 8'h1);
      chk("ms.frz_rs1", 8'(rs1mux_sel), 8'h1);
    end
    mem_stall = 1'b0; #1;
    chk("ms.rel_stall", 8'(stall_id), 8'h1);
    tick();
    chk("ms.one_stall", 8'(stall_id), 8'h0);
    chk("ms.bub_rs1", 8'(rs1mux_sel), 8'h0);
    tick();
    chk("ms.rs1", 8'(rs1mux_sel), 8'h2);
    chk("ms.rs2", 8'(rs2mux_sel), 8'h2);

    // Reset asserted while in LU_STALL
    drain();
    alu(1, 2, 3); tick();
    lw(8, 1); tick();
    alu(9, 8, 8); #1;
    chk("rs.stall", 8'(stall_id), 8'h1);
    tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    chk_all_zero("rs");
    tick();
    chk("rs.after_rs1", 8'(rs1mux_sel), 8'h0);
    chk("rs.after_stall", 8'(stall_id), 8'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
